alu_share_arbiter: RTL

- Shares the single combinational 32-bit ALU between two requesters: port 0 is the pipeline execute-side helper, port 1 is the CSR unit.
- Each port uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers the operands that drive the ALU, captures the ALU result, and holds the response until the requester accepts it.
- One operation is in flight at a time.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters: port 0 is the
//   execute-side helper, port 1 is the CSR unit. One operation is in flight
//   at a time. Grants alternate round-robin when both ports request together.
//
// Handshake rule (both request and response channels): a transfer happens on
//   a rising clk edge where valid && ready are both high. A valid source holds
//   its payload stable until that edge. Ready may depend combinationally on
//   valid; valid never depends on ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready[1:0] per-port request channel
//   req_a/req_b  [2*WIDTH]   operands, port i at [i*WIDTH +: WIDTH]
//   req_op       [2*OPW]     ALU control code, port i at [i*OPW +: OPW]
//   rsp_valid/rsp_ready[1:0] per-port response channel
//   rsp_data     [WIDTH]     shared result, valid for the port with rsp_valid
//   alu_a/alu_b/alu_ctrl     registered drive to the ALU
//   alu_result   [WIDTH]     combinational result from the ALU
//   dbg_state    [1:0]       FSM state (0 IDLE, 1 EXEC, 2 RESP)
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [2*OPW-1:0]     req_op,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [OPW-1:0]       alu_ctrl,
  input  logic [WIDTH-1:0]     alu_result,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_gnt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [OPW-1:0]    r_op;
  logic [WIDTH-1:0]  r_rsp;

  logic              w_gnt;
  logic              w_accept;
  logic              w_rsp_hs;

  // Round-robin pick: a lone requester wins; on a tie the port that was not
  // served last wins. Reset leaves last_grant = 1 so port 0 goes first.
  always_comb begin
    w_gnt = 1'b0;
    case (req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last_grant;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && (|req_valid) && !rst;
  // Only the granted port's rsp_ready matters; the other is ignored.
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_gnt];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (w_accept) req_ready[w_gnt] = 1'b1;
    if ((r_state == S_RESP) && !rst) rsp_valid[r_gnt] = 1'b1;
  end

  // Datapath: operands latch on accept and stay put through EXEC and RESP so
  // the ALU inputs are stable; the result is captured at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp        <= '0;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_a   <= w_gnt ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        r_b   <= w_gnt ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        r_op  <= w_gnt ? req_op[OPW +: OPW]    : req_op[0 +: OPW];
        r_gnt <= w_gnt;
      end
      if (r_state == S_EXEC) r_rsp <= alu_result;
      if (w_rsp_hs) r_last_grant <= r_gnt;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_ctrl  = r_op;
  assign rsp_data  = r_rsp;
  assign dbg_state = r_state;

endmodule
